sprite_engine: RTL
==================

// Module: sprite_engine
// PURPOSE
//  Parametrised successor to the fixed centred sprite display: draws one animated sprite at a runtime position
//  with colour-key transparency, reading from an external single-port sprite ROM. Sits between the VGA
//  counter (h_cnt/v_cnt) and the pixel mux; several instances (win, lose, player, fungi) share one VGA chain.
//  Position and enable are tear-free (frame-latched); ROM read latency is compensated internally.
// PARAMETERS
//  WIDTH        49     sprite width, pixels (1..640)
//  HEIGHT       46     sprite height, pixels (1..480)
//  FRAMES       1      animation frames stored back-to-back in ROM (1..16)
//  FRAME_HOLD   8      video frames each animation frame is held (1..255)
//  ROM_LAT      1      ROM read latency in pix_en ticks (1..3)
//  ADDR_W       17     rom_addr width; must hold FRAMES*WIDTH*HEIGHT-1
//  TRANSPARENT  12'h0F0 colour key; ROM texels equal to it are not drawn
//  V_ACTIVE     480    first blanking line; latch point for position/show
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  pix_en     in   1       pixel-rate tick (25 MHz enable); all state advances only when high
//  h_cnt      in   10      VGA horizontal count, valid with pix_en
//  v_cnt      in   10      VGA vertical count, valid with pix_en
//  x_in       in   10      sprite top-left x (sampled at frame latch)
//  y_in       in   10      sprite top-left y (sampled at frame latch)
//  show       in   1       sprite visible request (sampled at frame latch)
//  anim_en    in   1       1 = advance animation; 0 = freeze current frame
//  rom_addr   out  ADDR_W  registered ROM address
//  rom_data   in   12      ROM texel, valid ROM_LAT ticks after rom_addr
//  pixel      out  12      RGB444 colour, aligned with sprite_on
//  sprite_on  out  1       1 = pixel is an opaque sprite texel
// BEHAVIOUR
//  - One clock; synchronous active-high rst. Reset: rom_addr=0, pixel=0, sprite_on=0, latched x/y=0,
//    latched show=0, frame_idx=0, hold_cnt=0, pipeline valid bits cleared. Nothing drawn until first latch.
//  - Frame latch: on pix_en with h_cnt==0 && v_cnt==V_ACTIVE: x_l<=x_in, y_l<=y_in, show_l<=show; animation
//    update same tick: if anim_en: hold_cnt==FRAME_HOLD-1 -> hold_cnt<=0, frame_idx<=(frame_idx==FRAMES-1)?0:+1;
//    else hold_cnt++. anim_en=0 -> hold_cnt and frame_idx hold. FRAMES==1 -> frame_idx stays 0.
//  - Hit test (stage 0, 11-bit unsigned, no wrap): in_box = show_l && h_cnt>=x_l && h_cnt<x_l+WIDTH
//    && v_cnt>=y_l && v_cnt<y_l+HEIGHT. Sprite extending past 639/479 is clipped by the counters, not wrapped.
//  - Address (stage 0 -> reg): rom_addr <= frame_idx*WIDTH*HEIGHT + (v_cnt-y_l)*WIDTH + (h_cnt-x_l) when
//    in_box, else rom_addr holds. Multiply by constants only.
//  - Pipeline: in_box delayed 1+ROM_LAT pix_en ticks alongside rom_data. Output reg: sprite_on <=
//    vld && rom_data!=TRANSPARENT; pixel <= sprite_on-next ? rom_data : 12'h000.
//  - Latency: h_cnt/v_cnt at tick N -> pixel/sprite_on at tick N+ROM_LAT+2 (ROM_LAT=1: 3 ticks). Caller
//    delays h/v-sync by the same amount. Without pix_en, all registers hold.
//  - Position change mid-frame has no visible effect until next latch (no tearing).
//  - rst mid-frame: outputs 0 next clk; drawing resumes after next latch point.
// CONFIGURATION
//  BLINK_EN defined: extra parameter BLINK_FRAMES (default 30); blink counter counts latch events;
//    on reaching BLINK_FRAMES-1 it wraps and toggles blink_ph (reset 1). in_box additionally ANDed with
//    blink_ph -> sprite visible BLINK_FRAMES frames, hidden BLINK_FRAMES frames. Counter/phase reset on rst
//    and when show_l==0 (restart visible).
//  BLINK_EN undefined: no blink counter; visibility depends on show_l only.
// TESTING
//  T1 reset: rst=1 2 clks, show=1 -> sprite_on=0, pixel=0 until first latch; after latch with x=100,y=50,
//     h=100,v=50 -> rom_addr=0, sprite_on=1 3 ticks later (ROM_LAT=1, opaque texel).
//  T2 addressing: x=10,y=20,W=49; probe h=12,v=23 -> rom_addr=3*49+2=149; h=59 (x+W) -> no hit, addr holds.
//  T3 transparency: ROM returns 12'h0F0 inside box -> sprite_on=0, pixel=0; 12'hF00 -> sprite_on=1, pixel=F00.
//  T4 clipping: x=620,W=49 -> hits h=620..639 only; no hit at h=0..28 of same line; same for y=470.
//  T5 animation: FRAMES=3,FRAME_HOLD=2,anim_en=1 -> frame_idx 0,0,1,1,2,2,0 over 7 latches; offset
//     frame*W*H at h=x,v=y (0,2254,4508); anim_en=0 freezes.
//  T6 tear-free/blink: change x_in mid-frame -> old x until latch; with BLINK_EN,BLINK_FRAMES=2 ->
//     visible 2 frames, hidden 2 frames, repeating.

Source files
------------

// File: rtl/sprite_engine.sv
// -----------------------------------------------------------------------------
// sprite_engine
//   Draws one animated sprite at a runtime position over the VGA raster.
//   Texels are read from an external single-port sprite ROM. Texels equal to
//   the colour key are not drawn. Position, visibility and the animation frame
//   change only at the frame latch point (h_cnt==0, v_cnt==V_ACTIVE), so a
//   moving sprite never tears. The ROM read latency is absorbed by a valid
//   pipeline, so pixel/sprite_on appear ROM_LAT+2 pix_en ticks after the
//   h_cnt/v_cnt that produced them.
//
// Optional feature macro: BLINK_EN
//   When defined, the sprite blinks: BLINK_FRAMES frames visible, then
//   BLINK_FRAMES frames hidden. Any frame with show_l low restarts the blink
//   in the visible phase.
//
// Ports
//   clk        in   1       system clock
//   rst        in   1       synchronous reset, active-high
//   pix_en     in   1       pixel-rate tick; all state advances only when high
//   h_cnt      in   10      VGA horizontal count
//   v_cnt      in   10      VGA vertical count
//   x_in       in   10      sprite top-left x (taken at frame latch)
//   y_in       in   10      sprite top-left y (taken at frame latch)
//   show       in   1       sprite visible request (taken at frame latch)
//   anim_en    in   1       1 = advance animation, 0 = freeze current frame
//   rom_addr   out  ADDR_W  registered ROM address
//   rom_data   in   12      ROM texel, valid ROM_LAT ticks after rom_addr
//   pixel      out  12      RGB444 colour, 0 when sprite_on is low
//   sprite_on  out  1       1 = pixel is an opaque sprite texel
// -----------------------------------------------------------------------------
module sprite_engine #(
  parameter int          WIDTH       = 49,
  parameter int          HEIGHT      = 46,
  parameter int          FRAMES      = 1,
  parameter int          FRAME_HOLD  = 8,
  parameter int          ROM_LAT     = 1,
  parameter int          ADDR_W      = 17,
  parameter logic [11:0] TRANSPARENT = 12'h0F0,
  parameter int          V_ACTIVE    = 480
`ifdef BLINK_EN
  ,
  parameter int          BLINK_FRAMES = 30
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic              show,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [11:0]       pixel,
  output logic              sprite_on
);

  localparam logic [10:0]       WIDTH_L    = 11'(WIDTH);
  localparam logic [10:0]       HEIGHT_L   = 11'(HEIGHT);
  localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A    = ADDR_W'(WIDTH);
  localparam logic [7:0]        HOLD_LAST  = 8'(FRAME_HOLD - 1);
  localparam logic [3:0]        FRAME_LAST = 4'(FRAMES - 1);
  localparam logic [9:0]        V_LATCH    = 10'(V_ACTIVE);

  // Frame-latched state
  logic [9:0]        x_l_r;
  logic [9:0]        y_l_r;
  logic              show_l_r;
  logic [3:0]        frame_idx_r;
  logic [7:0]        hold_cnt_r;

  // Stage-0 combinational signals
  logic              latch_s;
  logic              blink_ok_s;
  logic              in_box_s;
  logic [9:0]        dx_s;
  logic [9:0]        dy_s;
  logic [ADDR_W-1:0] addr_s;
  logic              opaque_s;

  // in_box travels alongside the ROM read; bit ROM_LAT lines up with rom_data
  logic [ROM_LAT:0]  vld_r;

  assign latch_s = pix_en && (h_cnt == 10'd0) && (v_cnt == V_LATCH);

`ifdef BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic [15:0] blink_cnt_r;
  logic        blink_ph_r;

  // Blink phase: counts latch events, toggles visibility every BLINK_FRAMES
  // frames; restarts visible whenever the sprite is not shown.
  always_ff @(posedge clk) begin
    if (rst || !show_l_r) begin
      blink_cnt_r <= 16'd0;
      blink_ph_r  <= 1'b1;
    end else if (latch_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= 16'd0;
        blink_ph_r  <= ~blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 16'd1;
      end
    end
  end

  assign blink_ok_s = blink_ph_r;
`else
  assign blink_ok_s = 1'b1;
`endif

  // Frame latch: position/visibility snapshot and animation frame stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      x_l_r       <= 10'd0;
      y_l_r       <= 10'd0;
      show_l_r    <= 1'b0;
      frame_idx_r <= 4'd0;
      hold_cnt_r  <= 8'd0;
    end else if (latch_s) begin
      x_l_r    <= x_in;
      y_l_r    <= y_in;
      show_l_r <= show;
      if (anim_en) begin
        if (hold_cnt_r == HOLD_LAST) begin
          hold_cnt_r  <= 8'd0;
          frame_idx_r <= (frame_idx_r == FRAME_LAST) ? 4'd0 : frame_idx_r + 4'd1;
        end else begin
          hold_cnt_r <= hold_cnt_r + 8'd1;
        end
      end
    end
  end

  // Stage 0: hit test in 11 bits so a box running past the screen edge is
  // clipped by the counters instead of wrapping; ROM address from offsets.
  always_comb begin
    in_box_s = show_l_r && blink_ok_s
               && ({1'b0, h_cnt} >= {1'b0, x_l_r})
               && ({1'b0, h_cnt} <  ({1'b0, x_l_r} + WIDTH_L))
               && ({1'b0, v_cnt} >= {1'b0, y_l_r})
               && ({1'b0, v_cnt} <  ({1'b0, y_l_r} + HEIGHT_L));
    dx_s     = h_cnt - x_l_r;
    dy_s     = v_cnt - y_l_r;
    addr_s   = (ADDR_W'(frame_idx_r) * FRAME_SIZE)
               + (ADDR_W'(dy_s) * WIDTH_A)
               + ADDR_W'(dx_s);
  end

  // Address register and hit-valid pipeline; the address holds outside the box
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      vld_r    <= '0;
    end else if (pix_en) begin
      if (in_box_s) begin
        rom_addr <= addr_s;
      end
      vld_r <= {vld_r[ROM_LAT-1:0], in_box_s};
    end
  end

  assign opaque_s = vld_r[ROM_LAT] && (rom_data != TRANSPARENT);

  // Output register: colour-keyed texel, black when not drawing
  always_ff @(posedge clk) begin
    if (rst) begin
      sprite_on <= 1'b0;
      pixel     <= 12'h000;
    end else if (pix_en) begin
      sprite_on <= opaque_s;
      pixel     <= opaque_s ? rom_data : 12'h000;
    end
  end

endmodule
